// File: rtl/ex_div_sequencer.sv
// EX-stage divide sequencer: 32-step restoring divider for DIV/DIVU with
// divide-by-zero, annul and downstream-hold handling. The result is
// presented as {remainder, quotient}.
module ex_div_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req,
  input  logic        div_signed,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        annul,
  input  logic        ex_hold,
  output logic        stallreq_for_div,
  output logic        result_valid,
  output logic [63:0] div_result,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] dvd_quo;   // dividend bits shift out of the top, quotient bits shift in at the bottom
  logic [31:0] dvs;
  logic [31:0] rem;
  logic        dvd_neg;
  logic        dvs_neg;
  logic        start;
  logic [32:0] trial;
  logic        trial_ok;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;

  // Magnitude of an operand; only signed operands with the top bit set are negated.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
    logic signed [31:0] sv;
    sv = v;
    return (sgn && sv < 0) ? 32'(-sv) : v;
  endfunction

  // Two's-complement negate when requested, modulo 2^32.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    logic signed [31:0] sv;
    sv = v;
    return neg ? 32'(-sv) : v;
  endfunction

  assign start    = (state == S_IDLE) && div_req && !annul;
  // Remainder stays below the divisor, so the 33-bit trial never overflows.
  assign trial    = {rem, dvd_quo[31]} - {1'b0, dvs};
  assign trial_ok = ~trial[32];
  assign rem_nxt  = trial_ok ? trial[31:0] : {rem[30:0], dvd_quo[31]};
  assign quo_nxt  = {dvd_quo[30:0], trial_ok};

  assign stallreq_for_div = !annul && (((state == S_IDLE) && div_req) ||
                                       (state == S_DIVZERO) || (state == S_ON));
  assign result_valid     = (state == S_END);
  assign busy             = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; annul returns any active state to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = (opdata2 == 32'd0) ? S_DIVZERO : S_ON;
      S_DIVZERO: state_nxt = annul ? S_IDLE : S_END;
      S_ON:      if (annul) state_nxt = S_IDLE;
                 else if (cnt == 5'd31) state_nxt = S_END;
      S_END:     if (annul || !ex_hold) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 5'd0;
      dvd_quo    <= 32'd0;
      dvs        <= 32'd0;
      rem        <= 32'd0;
      dvd_neg    <= 1'b0;
      dvs_neg    <= 1'b0;
      div_result <= 64'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            dvd_quo <= magnitude(opdata1, div_signed);
            dvs     <= magnitude(opdata2, div_signed);
            rem     <= 32'd0;
            cnt     <= 5'd0;
            dvd_neg <= div_signed & opdata1[31];
            dvs_neg <= div_signed & opdata2[31];
          end
        end
        S_DIVZERO: begin
          if (!annul) div_result <= 64'd0;
        end
        S_ON: begin
          if (!annul) begin
            rem     <= rem_nxt;
            dvd_quo <= quo_nxt;
            cnt     <= cnt + 5'd1;
            // Final step: sign-correct and register the result on entry to END.
            if (cnt == 5'd31)
              div_result <= {neg_if(rem_nxt, dvd_neg), neg_if(quo_nxt, dvd_neg ^ dvs_neg)};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_sequencer.sv
// Scoreboard bench for ex_div_sequencer: stimulus pushes expected results,
// a negedge monitor pops and compares on each new result_valid.
module tb_ex_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_req;
  logic        div_signed;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic        ex_hold;
  logic        stallreq_for_div;
  logic        result_valid;
  logic [63:0] div_result;
  logic        busy;

  typedef struct {
    logic [63:0] res;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic prev_valid = 1'b0;

  ex_div_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .div_req          (div_req),
    .div_signed       (div_signed),
    .opdata1          (opdata1),
    .opdata2          (opdata2),
    .annul            (annul),
    .ex_hold          (ex_hold),
    .stallreq_for_div (stallreq_for_div),
    .result_valid     (result_valid),
    .div_result       (div_result),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  endtask

  // Monitor: one scoreboard entry per new result_valid, checks value and cycle.
  always @(negedge clk) begin
    if (result_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_result: got %h, expected no result (cycle %0d)", div_result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", div_result, e.res);
        chk("valid_cycle", 64'(cyc), 64'(e.at));
      end
    end
    prev_valid <= result_valid;
  end

  // Issue one divide (called just after a rising edge with the FSM idle),
  // optionally holding END for 'hold' extra cycles.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat, input int hold);
    int stall_cnt;
    bit seen;
    exp_t e;
    div_req    = 1'b1;
    div_signed = sgn;
    opdata1    = a;
    opdata2    = b;
    e.res = exp;
    e.at  = cyc + lat;
    sb.push_back(e);
    stall_cnt = 0;
    seen = 1'b0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (result_valid) begin
        seen = 1'b1;
        break;
      end
      if (stallreq_for_div) stall_cnt++;
    end
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: got no result_valid, expected one within 80 cycles");
      finish_run();
    end
    chk("stall_cycles", 64'(stall_cnt), 64'(lat));
    chk("stall_in_end", {63'd0, stallreq_for_div}, 64'd0);
    ex_hold = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {63'd0, result_valid}, 64'd1);
      chk("hold_result", div_result, exp);
      chk("hold_stall", {63'd0, stallreq_for_div}, 64'd0);
      if (i == hold - 1) ex_hold = 1'b0;
    end
    @(posedge clk); #1;
    div_req = 1'b0;
    chk("idle_after_end", {62'd0, busy, result_valid}, 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    div_req    = 1'b0;
    div_signed = 1'b0;
    opdata1    = 32'd0;
    opdata2    = 32'd0;
    annul      = 1'b0;
    ex_hold    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy",   {63'd0, busy}, 64'd0);
    chk("rst_stall",  {63'd0, stallreq_for_div}, 64'd0);
    chk("rst_valid",  {63'd0, result_valid}, 64'd0);
    chk("rst_result", div_result, 64'd0);

    @(posedge clk); #1;
    run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0);
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 0);
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 33, 0);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33, 0);
    run_div(1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0}, 33, 0);
    run_div(1'b0, 32'h12345678, 32'd0, 64'd0, 2, 0);
    run_div(1'b1, 32'hFFFFFFFB, 32'd0, 64'd0, 2, 0);
    run_div(1'b0, 32'd1000, 32'd7, {32'd6, 32'd142}, 33, 3);

    // Annul in the middle of ON.
    div_req    = 1'b1;
    div_signed = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    #1;
    chk("annul_stall", {63'd0, stallreq_for_div}, 64'd0);
    @(posedge clk); #1;
    annul   = 1'b0;
    div_req = 1'b0;
    chk("annul_busy",   {63'd0, busy}, 64'd0);
    chk("annul_valid",  {63'd0, result_valid}, 64'd0);
    chk("annul_result", div_result, {32'd6, 32'd142});
    run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0);

    // Back-to-back: the second request is seen in the IDLE cycle after END.
    run_div(1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 33, 0);
    run_div(1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, 33, 0);

    // Reset in the middle of a divide.
    div_req    = 1'b1;
    div_signed = 1'b0;
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    repeat (5) @(posedge clk);
    #1;
    rst     = 1'b1;
    div_req = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_busy",   {63'd0, busy}, 64'd0);
    chk("mid_rst_stall",  {63'd0, stallreq_for_div}, 64'd0);
    chk("mid_rst_valid",  {63'd0, result_valid}, 64'd0);
    chk("mid_rst_result", div_result, 64'd0);
    rst = 1'b0;

    repeat (40) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    finish_run();
  end

endmodule
